// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, tables and mode helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        AES128  = 2'b00,
        AES192  = 2'b01,
        AES256  = 2'b10,
        AES_ILL = 2'b11
    } aes_mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GEN   = 2'd1,
        S_DRAIN = 2'd2
    } kx_state_e;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Key length in 32-bit words.
    function automatic logic [3:0] nk_of(input aes_mode_e m);
        case (m)
            AES128:  return 4'd4;
            AES192:  return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    // Number of cipher rounds (round keys = nr + 1).
    function automatic logic [3:0] nr_of(input aes_mode_e m);
        case (m)
            AES128:  return 4'd10;
            AES192:  return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule. One schedule word per un-stalled
// cycle, four words packed into each round key, streamed over valid/ready.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [MAX_KEY_BITS-1:0] key,
    output logic [127:0]            rk,
    output logic [3:0]              rk_idx,
    output logic                    rk_last,
    output logic                    rk_valid,
    input  logic                    rk_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    kx_state_e               state;
    logic [3:0]              nk_q, nr_q;
    logic [5:0]              j_q;      // index of the next word to generate
    logic [2:0]              kpos_q;   // j_q mod Nk
    logic [3:0]              ri_q;     // next RCON entry
    logic [MAX_KEY_BITS-1:0] key_q;    // unconsumed key words, next one in [31:0]
    logic [7:0][31:0]        win;      // win[0] = w[j-1], win[i] = w[j-1-i]
    logic [2:0][31:0]        pk;       // first three words of the round key being built
    logic [1:0]              pcnt;
    logic [3:0]              nidx;     // round number of the next round key

    logic        mode_ok, cap, stall, commit, wr, hs, key_phase, last_word;
    logic        rot_case, sub_case;
    logic [31:0] prev, old, sb_in, sb_out, t, w_new, word;

    assign mode_ok   = (mode != AES_ILL) &&
                       (32 * int'(nk_of(aes_mode_e'(mode))) <= MAX_KEY_BITS);
    assign cap       = (state == S_IDLE) && start && mode_ok;
    assign hs        = rk_valid && rk_ready;
    // Only the word that completes a round key can be blocked by the output slot.
    assign stall     = (pcnt == 2'd3) && rk_valid && !rk_ready;
    assign commit    = (state == S_GEN) && !stall;
    // The capture cycle commits w[0] directly from the key port, which is
    // what puts round key 0 on the output four cycles after start.
    assign wr        = cap || commit;
    assign key_phase = j_q < {2'b00, nk_q};
    assign last_word = j_q == {nr_q, 2'b11};

    assign prev     = win[0];
    assign old      = win[3'(nk_q - 4'd1)];
    assign rot_case = (kpos_q == 3'd0);
    assign sub_case = (nk_q == 4'd8) && (kpos_q == 3'd4);
    // RotWord: byte 0 sits in [7:0], so rotating bytes left is a right shift.
    assign sb_in    = rot_case ? {prev[7:0], prev[31:8]} : prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (sb_in[8*b +: 8]),
            .dout (sb_out[8*b +: 8])
        );
    end

    // Next schedule word from the window and the shared SubWord result.
    always_comb begin
        t = prev;
        if (rot_case)
            t = sb_out ^ {24'h0, RCON[ri_q]};
        else if (sub_case)
            t = sb_out;
        w_new = key_phase ? key_q[31:0] : (old ^ t);
        word  = cap ? key[31:0] : w_new;
    end

    // Control FSM: capture, word/rcon counters, busy/done/err pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            nk_q   <= '0;
            nr_q   <= '0;
            j_q    <= '0;
            kpos_q <= '0;
            ri_q   <= '0;
            key_q  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (mode_ok) begin
                            state  <= S_GEN;
                            busy   <= 1'b1;
                            nk_q   <= nk_of(aes_mode_e'(mode));
                            nr_q   <= nr_of(aes_mode_e'(mode));
                            key_q  <= key >> 32;
                            j_q    <= 6'd1;
                            kpos_q <= 3'd1;
                            ri_q   <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_GEN: begin
                    if (commit) begin
                        j_q    <= j_q + 6'd1;
                        kpos_q <= ({1'b0, kpos_q} == nk_q - 4'd1) ? 3'd0 : kpos_q + 3'd1;
                        if (key_phase)
                            key_q <= key_q >> 32;
                        else if (rot_case)
                            ri_q <= ri_q + 4'd1;
                        if (last_word)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (hs) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Word window, packer and round-key output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win      <= '0;
            pk       <= '0;
            pcnt     <= '0;
            nidx     <= '0;
            rk       <= '0;
            rk_idx   <= '0;
            rk_last  <= 1'b0;
            rk_valid <= 1'b0;
        end else begin
            if (hs)
                rk_valid <= 1'b0;
            if (wr) begin
                win <= {win[6:0], word};
                if (cap) begin
                    pk[0] <= word;
                    pcnt  <= 2'd1;
                    nidx  <= '0;
                end else if (pcnt == 2'd3) begin
                    rk       <= {word, pk[2], pk[1], pk[0]};
                    rk_valid <= 1'b1;
                    rk_idx   <= nidx;
                    rk_last  <= (nidx == nr_q);
                    nidx     <= nidx + 4'd1;
                    pcnt     <= 2'd0;
                end else begin
                    case (pcnt)
                        2'd0:    pk[0] <= word;
                        2'd1:    pk[1] <= word;
                        default: pk[2] <= word;
                    endcase
                    pcnt <= pcnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: known-answer table, reference
// schedule scoreboard, latency, backpressure, misuse and mid-run reset.
module tb_aes_key_expander;

    localparam logic [255:0] K1 = 256'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [255:0] K2 = 256'h7b6b2c52d2eaf862e57990802bf310c852640edaf7b0738e;
    localparam logic [255:0] K3 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] FULL  = '1;
    localparam logic [127:0] LOW32 = 128'hffffffff;

    typedef struct {
        logic [1:0]   mode;
        logic [255:0] key;
        int           idx;
        logic [127:0] mask;
        logic [127:0] exp;
    } kat_t;

    typedef struct {
        logic [127:0] rk;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n, start, rk_ready;
    logic [1:0]   mode;
    logic [255:0] key;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_last, rk_valid, busy, done, err;

    logic         start2;
    logic [1:0]   mode2;
    logic [127:0] key2;
    logic [127:0] rk2;
    logic [3:0]   rk_idx2;
    logic         rk_last2, rk_valid2, busy2, done2, err2;

    int           n_chk = 0, n_pass = 0;
    int           cyc = 0, c_acc = 0;
    int           hs_cnt, done_lat, exp_nr;
    int           hs_lat [16];
    logic [127:0] got [16];
    logic         done_seen, bp_en;
    logic         held_v = 1'b0;
    logic [127:0] held_rk;
    logic [3:0]   held_idx;
    exp_t         exp_q [$];
    exp_t         mon_e;
    kat_t         kat [7];

    aes_key_expander #(.MAX_KEY_BITS(256)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key(key),
        .rk(rk), .rk_idx(rk_idx), .rk_last(rk_last), .rk_valid(rk_valid),
        .rk_ready(rk_ready), .busy(busy), .done(done), .err(err)
    );

    aes_key_expander #(.MAX_KEY_BITS(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .key(key2),
        .rk(rk2), .rk_idx(rk_idx2), .rk_last(rk_last2), .rk_valid(rk_valid2),
        .rk_ready(1'b1), .busy(busy2), .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {aes_pkg::SBOX[x[31:24]], aes_pkg::SBOX[x[23:16]],
                aes_pkg::SBOX[x[15:8]],  aes_pkg::SBOX[x[7:0]]};
    endfunction

    // Straight FIPS-197 expansion over a full w[] array; pushes every round key.
    task automatic load_model(input logic [1:0] m, input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        exp_t        e;
        int          nk, nr;
        nk = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
        nr = nk + 6;
        rc = 8'h01;
        for (int j = 0; j < 4*nr + 4; j++) begin
            if (j < nk) begin
                w[j] = k[32*j +: 32];
            end else begin
                t = w[j-1];
                if (j % nk == 0) begin
                    t  = subw({t[7:0], t[31:8]}) ^ {24'h0, rc};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk == 8 && j % nk == 4) begin
                    t = subw(t);
                end
                w[j] = w[j-nk] ^ t;
            end
        end
        for (int i = 0; i <= nr; i++) begin
            e.rk   = {w[4*i+3], w[4*i+2], w[4*i+1], w[4*i]};
            e.idx  = 4'(i);
            e.last = (i == nr);
            exp_q.push_back(e);
        end
        exp_nr = nr;
    endtask

    task automatic run_start(input logic [1:0] m, input logic [255:0] k);
        @(posedge clk); #1;
        start = 1'b1; mode = m; key = k;
        @(posedge clk); #1;
        c_acc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_seen, 1'b1);
    endtask

    task automatic run(input logic [1:0] m, input logic [255:0] k, input int budget, input bit poke);
        exp_q.delete();
        done_seen = 1'b0;
        hs_cnt = 0;
        for (int i = 0; i < 16; i++) begin got[i] = '0; hs_lat[i] = 0; end
        load_model(m, k);
        run_start(m, k);
        if (poke) begin
            repeat (8) @(posedge clk);
            #1; start = 1'b1; mode = 2'b10; key = K3;
            repeat (3) @(posedge clk);
            #1; chk("busy_during_poke", busy, 1'b1);
            start = 1'b0; mode = 2'b00; key = '0;
        end
        wait_done(budget);
        chk("hs_count", hs_cnt, exp_nr + 1);
        chk("sb_drained", exp_q.size(), 0);
        chk("busy_after_done", busy, 1'b0);
    endtask

    task automatic check_latency();
        chk("lat_rk0", hs_lat[0], 4);
        chk("lat_rk1", hs_lat[1], 8);
        chk("lat_rk10", hs_lat[10], 44);
        chk("lat_done", done_lat, 45);
    endtask

    initial forever begin
        @(posedge clk); #1;
        rk_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: stall stability, scoreboard pop on handshake, done capture.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("stall_valid", rk_valid, 1'b1);
                chk("stall_rk", rk, held_rk);
                chk("stall_idx", rk_idx, held_idx);
            end
            held_v   = rk_valid && !rk_ready;
            held_rk  = rk;
            held_idx = rk_idx;
            if (rk_valid && rk_ready) begin
                chk("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("rk", rk, mon_e.rk);
                    chk("rk_idx", rk_idx, mon_e.idx);
                    chk("rk_last", rk_last, mon_e.last);
                end
                got[rk_idx]    = rk;
                hs_lat[rk_idx] = cyc - c_acc + 1;
                hs_cnt++;
            end
            if (done) begin
                done_seen = 1'b1;
                done_lat  = cyc - c_acc + 1;
                chk("busy_at_done", busy, 1'b0);
            end
        end
    end

    initial begin
        kat[0] = '{2'b00, K1, 0,  FULL,  128'h3c4fcf098815f7aba6d2ae2816157e2b};
        kat[1] = '{2'b00, K1, 1,  FULL,  128'h05766c2a3939a323b12c548817fefaa0};
        kat[2] = '{2'b00, K1, 10, FULL,  128'ha60c63b6c80c3fe18925eec9a8f914d0};
        kat[3] = '{2'b01, K2, 12, FULL,  128'h022200010472cc8e3c778c446fa08be9};
        kat[4] = '{2'b10, K3, 1,  FULL,  128'h1f1e1d1c1b1a19181716151413121110};
        kat[5] = '{2'b10, K3, 2,  LOW32, 128'h9fc273a5};
        kat[6] = '{2'b10, K3, 14, FULL,  128'h36de686d3cc21a37e97909bfcc79fc24};

        rst_n = 1'b0; start = 1'b0; mode = '0; key = '0; rk_ready = 1'b1; bp_en = 1'b0;
        start2 = 1'b0; mode2 = '0; key2 = '0; done_seen = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_rk", rk, '0);
        chk("rst_rk_idx", rk_idx, '0);
        chk("rst_rk_last", rk_last, 1'b0);
        chk("rst_rk_valid", rk_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;

        // Known-answer table, each entry a full scoreboarded run.
        for (int i = 0; i < 7; i++) begin
            run(kat[i].mode, kat[i].key, 300, 1'b0);
            chk($sformatf("kat%0d", i), got[kat[i].idx] & kat[i].mask, kat[i].exp & kat[i].mask);
        end

        // AES-128 timing with the consumer always ready.
        run(2'b00, K1, 300, 1'b0);
        check_latency();

        // Pseudo-random backpressure.
        bp_en = 1'b1;
        run(2'b00, K1, 1500, 1'b0);
        bp_en = 1'b0;
        chk("bp_kat10", got[10], 128'ha60c63b6c80c3fe18925eec9a8f914d0);

        // Illegal mode.
        run_start(2'b11, K1);
        @(negedge clk);
        chk("ill_err", err, 1'b1);
        chk("ill_busy", busy, 1'b0);
        @(negedge clk);
        chk("ill_err_pulse", err, 1'b0);
        chk("ill_busy2", busy, 1'b0);

        // Mode too wide for a 128-bit instance, then a legal one.
        @(posedge clk); #1; start2 = 1'b1; mode2 = 2'b10; key2 = K1[127:0];
        @(posedge clk); #1; start2 = 1'b0;
        chk("narrow_err", err2, 1'b1);
        chk("narrow_busy", busy2, 1'b0);
        @(posedge clk); #1; start2 = 1'b1; mode2 = 2'b00;
        @(posedge clk); #1; start2 = 1'b0;
        chk("narrow_ok_busy", busy2, 1'b1);
        chk("narrow_ok_err", err2, 1'b0);

        // start pulses while busy must not disturb the schedule.
        run(2'b00, K1, 300, 1'b1);

        // Reset in the middle of a run, then a clean repeat.
        exp_q.delete();
        done_seen = 1'b0;
        load_model(2'b00, K1);
        run_start(2'b00, K1);
        begin
            int n = 0;
            while (!(rk_valid && rk_idx == 4'd5) && n < 200) begin
                @(posedge clk); #2;
                n++;
            end
        end
        chk("mid_reach_idx5", {rk_valid, rk_idx}, {1'b1, 4'd5});
        rst_n = 1'b0;
        #1;
        chk("mid_rk", rk, '0);
        chk("mid_rk_valid", rk_valid, 1'b0);
        chk("mid_rk_idx", rk_idx, '0);
        chk("mid_rk_last", rk_last, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", done, 1'b0);
        exp_q.delete();
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_no_done", done_seen, 1'b0);
        run(2'b00, K1, 300, 1'b0);
        check_latency();
        chk("mid_rerun_rk1", got[1], 128'h05766c2a3939a323b12c548817fefaa0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
